uart_wb_bridge: RTL and testbench

- Byte-stream command bridge between a UART byte interface and a pipelined Wishbone master port in the controller clock domain.
- Successor to the single-character letter-to-address demo logic. Adds parametrised multi-byte address/data, explicit write/read command framing, write acknowledgement, Wishbone timeout, overrun detection and serialised read responses.
- Sits between uart_rx/uart_tx and ddr3_top's first Wishbone port.

---
 rtl/uart_wb_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// ---------------------------------------------------------------------------
// uart_wb_bridge
//
// Turns a UART byte stream into single pipelined Wishbone transactions.
//
// Command framing (all multi-byte fields are sent MSB first):
//   'W' (0x57) + ADDR_BYTES address bytes + DATA_BYTES data bytes -> write
//   'R' (0x52) + ADDR_BYTES address bytes                         -> read
// Responses on the TX side:
//   read           -> DATA_BYTES bytes of read data, MSB first
//   write          -> 'K' (0x4B) when ACK_WRITES != 0, otherwise nothing
//   unknown byte   -> '?' (0x3F)
//   bus timeout    -> 'T' (0x54)
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_enable           RX bytes are parsed only while high
//   i_rx_valid/data    one-cycle RX byte strobe and byte
//   o_tx_en/data       one-cycle TX byte strobe and byte
//   i_tx_busy          UART transmitter busy
//   o_wb_*/i_wb_*      pipelined Wishbone master port
//   o_busy             high whenever the bridge is not idle
//   o_overrun          sticky: an RX byte arrived while a command was in flight
//   o_timeout          sticky: a Wishbone access was aborted for lack of ack
// ---------------------------------------------------------------------------
module uart_wb_bridge #(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int ACK_WRITES = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_data,
    output logic                     o_tx_en,
    output logic [7:0]               o_tx_data,
    input  logic                     i_tx_busy,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [ADDR_BITS-1:0]     o_wb_addr,
    output logic [DATA_BITS-1:0]     o_wb_data,
    output logic [DATA_BITS/8-1:0]   o_wb_sel,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_ack,
    input  logic [DATA_BITS-1:0]     i_wb_data,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic                     o_timeout
);

    localparam int ADDR_BYTES = (ADDR_BITS + 7) / 8;
    localparam int DATA_BYTES = DATA_BITS / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);
    localparam int TXC_W      = $clog2(DATA_BYTES + 1);
    // Saturating timeout counter; kept at one bit when the timeout is disabled.
    localparam int TO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [7:0] CMD_WRITE  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR    = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TMO    = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WB_REQ,
        S_WB_WAIT,
        S_TX_SEND,
        S_TX_WAIT
    } state_t;

    state_t                 state_q,    state_d;
    logic                   we_q,       we_d;
    logic [ADDR_BITS-1:0]   addr_q,     addr_d;
    logic [DATA_BITS-1:0]   data_q,     data_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [TO_W-1:0]        to_q,       to_d;
    logic [DATA_BITS-1:0]   tx_q,       tx_d;
    logic [TXC_W-1:0]       tx_left_q,  tx_left_d;
    logic                   tx_en_q,    tx_en_d;
    logic                   tx_hold_q,  tx_hold_d;
    logic                   overrun_q,  overrun_d;
    logic                   timeout_q,  timeout_d;
    logic                   ack_go;

    // Single response byte placed in the top byte of the TX shift register,
    // which is the byte presented on o_tx_data.
    function automatic logic [DATA_BITS-1:0] tx_single(input logic [7:0] b);
        logic [DATA_BITS-1:0] v;
        v = '0;
        v[DATA_BITS-1 -: 8] = b;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            tx_q      <= '0;
            tx_left_q <= '0;
            tx_en_q   <= 1'b0;
            tx_hold_q <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            tx_q      <= tx_d;
            tx_left_q <= tx_left_d;
            tx_en_q   <= tx_en_d;
            tx_hold_q <= tx_hold_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        tx_d      = tx_q;
        tx_left_d = tx_left_q;
        tx_en_d   = 1'b0;
        tx_hold_d = tx_hold_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        ack_go    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && i_enable) begin
                    if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
                        we_d    = (i_rx_data == CMD_WRITE);
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        tx_d      = tx_single(RSP_ERR);
                        tx_left_d = TXC_W'(1);
                        state_d   = S_TX_SEND;
                    end
                end
            end

            S_ADDR: begin
                if (i_rx_valid && i_enable) begin
                    // Shifting through an ADDR_BITS-wide register keeps only
                    // the low ADDR_BITS bits of the received field.
                    addr_d = ADDR_BITS'({addr_q, i_rx_data});
                    if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = we_q ? S_DATA : S_WB_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (i_rx_valid && i_enable) begin
                    data_d = DATA_BITS'({data_q, i_rx_data});
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_WB_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_WB_REQ: begin
                if (!i_wb_stall) begin
                    to_d = '0;
                    // An ack in the accepting cycle completes the access at once.
                    if (i_wb_ack) begin
                        ack_go = 1'b1;
                    end else begin
                        state_d = S_WB_WAIT;
                    end
                end
            end

            S_WB_WAIT: begin
                if (i_wb_ack) begin
                    ack_go = 1'b1;
                end else if (TIMEOUT > 0 && to_q == TO_W'(TO_LAST)) begin
                    timeout_d = 1'b1;
                    tx_d      = tx_single(RSP_TMO);
                    tx_left_d = TXC_W'(1);
                    state_d   = S_TX_SEND;
                end else if (to_q != {TO_W{1'b1}}) begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_TX_SEND: begin
                if (!i_tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_hold_d = 1'b1;
                    state_d   = S_TX_WAIT;
                end
            end

            S_TX_WAIT: begin
                // The transmitter reports busy one cycle after the pulse, so
                // the first cycle here does not look at i_tx_busy.
                if (tx_hold_q) begin
                    tx_hold_d = 1'b0;
                end else if (!i_tx_busy) begin
                    if (tx_left_q > TXC_W'(1)) begin
                        tx_d      = tx_q << 8;
                        tx_left_d = tx_left_q - TXC_W'(1);
                        state_d   = S_TX_SEND;
                    end else begin
                        tx_left_d = '0;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ack_go) begin
            if (!we_q) begin
                tx_d      = i_wb_data;
                tx_left_d = TXC_W'(DATA_BYTES);
                state_d   = S_TX_SEND;
            end else if (ACK_WRITES != 0) begin
                tx_d      = tx_single(RSP_ACK);
                tx_left_d = TXC_W'(1);
                state_d   = S_TX_SEND;
            end else begin
                state_d = S_IDLE;
            end
        end

        // Bytes arriving while a command is in flight are dropped and flagged.
        if (i_rx_valid && (state_q inside {S_WB_REQ, S_WB_WAIT, S_TX_SEND, S_TX_WAIT})) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // ------------------------------------------------------------------
    assign o_wb_cyc  = (state_q == S_WB_REQ) || (state_q == S_WB_WAIT);
    assign o_wb_stb  = (state_q == S_WB_REQ);
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = data_q;
    assign o_wb_sel  = {DATA_BYTES{1'b1}};
    assign o_tx_en   = tx_en_q;
    assign o_tx_data = tx_q[DATA_BITS-1 -: 8];
    assign o_busy    = (state_q != S_IDLE);
    assign o_overrun = overrun_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// ---------------------------------------------------------------------------
// Bench for uart_wb_bridge. Stimulus pushes the expected Wishbone requests and
// TX bytes into queues; a negedge monitor pops and compares them whenever the
// DUT strobes a request or a TX byte. A second instance with ADDR_BITS=14
// covers address truncation.
// ---------------------------------------------------------------------------
module tb_uart_wb_bridge;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } wb_req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        rst, enable, rx_valid;
    logic [7:0]  rx_data;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_stall, wb_ack;
    logic [31:0] wb_rdata;
    logic        busy, overrun, timeout_f;

    // Second DUT (ADDR_BITS=14)
    logic        rx_valid2;
    logic [7:0]  rx_data2;
    logic        tx_en2;
    logic [7:0]  tx_data2;
    logic        cyc2, stb2, we2;
    logic [13:0] addr2;
    logic [31:0] wdata2;
    logic [3:0]  sel2;
    logic        busy2, overrun2, timeout2;

    // Scoreboard
    logic [7:0]  exp_tx[$];
    wb_req_t     exp_wb[$];
    logic [7:0]  exp_tx2[$];
    logic [13:0] exp_wb2[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Slave model configuration
    int          cfg_stall = 0;
    int          cfg_ack_delay = 0;
    bit          cfg_noack = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          slv_epoch = 0;
    int          slv_seen = 0;
    int          slv_stall_left = 0;
    int          slv_ack_cnt = 0;
    bit          slv_pending = 1'b0;

    // UART model / monitor state
    int          uart_cnt = 0;
    int          cyc_n = 0;
    int          acc_n = 0;
    int          drop_n = 0;
    logic        prev_tx_en = 1'b0;
    logic        prev_acc = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_cyc = 1'b0;
    logic [7:0]  mon_b;
    wb_req_t     mon_r;
    logic [13:0] mon_a;

    uart_wb_bridge #(
        .ADDR_BITS (32),
        .DATA_BITS (32),
        .ACK_WRITES(1),
        .TIMEOUT   (16)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enable  (enable),
        .i_rx_valid(rx_valid),
        .i_rx_data (rx_data),
        .o_tx_en   (tx_en),
        .o_tx_data (tx_data),
        .i_tx_busy (tx_busy),
        .o_wb_cyc  (wb_cyc),
        .o_wb_stb  (wb_stb),
        .o_wb_we   (wb_we),
        .o_wb_addr (wb_addr),
        .o_wb_data (wb_wdata),
        .o_wb_sel  (wb_sel),
        .i_wb_stall(wb_stall),
        .i_wb_ack  (wb_ack),
        .i_wb_data (wb_rdata),
        .o_busy    (busy),
        .o_overrun (overrun),
        .o_timeout (timeout_f)
    );

    uart_wb_bridge #(
        .ADDR_BITS (14),
        .DATA_BITS (32),
        .ACK_WRITES(0),
        .TIMEOUT   (4)
    ) u_dut14 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enable  (enable),
        .i_rx_valid(rx_valid2),
        .i_rx_data (rx_data2),
        .o_tx_en   (tx_en2),
        .o_tx_data (tx_data2),
        .i_tx_busy (1'b0),
        .o_wb_cyc  (cyc2),
        .o_wb_stb  (stb2),
        .o_wb_we   (we2),
        .o_wb_addr (addr2),
        .o_wb_data (wdata2),
        .o_wb_sel  (sel2),
        .i_wb_stall(1'b0),
        .i_wb_ack  (1'b0),
        .i_wb_data (32'h0),
        .o_busy    (busy2),
        .o_overrun (overrun2),
        .o_timeout (timeout2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_to(input int port, input logic [7:0] b);
        if (port == 0) begin
            rx_valid = 1'b1;
            rx_data  = b;
        end else begin
            rx_valid2 = 1'b1;
            rx_data2  = b;
        end
        tick();
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    task automatic send_seq(input logic [71:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_to(0, v[i*8 +: 8]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic push_wb(input logic we, input logic [31:0] a, input logic [31:0] d);
        wb_req_t r;
        r.we = we;
        r.addr = a;
        r.data = d;
        exp_wb.push_back(r);
    endtask

    task automatic push_tx32(input logic [31:0] v);
        for (int i = 3; i >= 0; i--) begin
            exp_tx.push_back(v[i*8 +: 8]);
        end
    endtask

    // Pipelined Wishbone slave: stall for cfg_stall stb cycles, then accept
    // and ack cfg_ack_delay cycles after the accepting cycle (0 = same cycle).
    initial begin
        wb_stall = 1'b0;
        wb_ack   = 1'b0;
        wb_rdata = '0;
        forever begin
            tick();
            wb_ack = 1'b0;
            if (slv_epoch != slv_seen) begin
                slv_seen       = slv_epoch;
                slv_stall_left = cfg_stall;
                slv_pending    = 1'b0;
            end
            if (slv_pending) begin
                slv_ack_cnt++;
                if (!cfg_noack && slv_ack_cnt >= cfg_ack_delay) begin
                    wb_ack      = 1'b1;
                    wb_rdata    = cfg_rdata;
                    slv_pending = 1'b0;
                end
            end else if (wb_stb) begin
                if (slv_stall_left > 0) begin
                    wb_stall = 1'b1;
                    slv_stall_left--;
                end else begin
                    wb_stall    = 1'b0;
                    slv_pending = 1'b1;
                    slv_ack_cnt = 0;
                    if (!cfg_noack && cfg_ack_delay == 0) begin
                        wb_ack      = 1'b1;
                        wb_rdata    = cfg_rdata;
                        slv_pending = 1'b0;
                    end
                end
            end else begin
                wb_stall = 1'b0;
            end
        end
    end

    // UART transmitter model: busy from the cycle after a pulse, for 4 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            tick();
            tx_busy = (uart_cnt > 0);
            if (tx_en) uart_cnt = 4;
            else if (uart_cnt > 0) uart_cnt--;
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!rst) begin
                if (tx_en) begin
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
                    end else begin
                        mon_b = exp_tx.pop_front();
                        check("tx_byte", tx_data, mon_b);
                    end
                    check("tx_while_busy", tx_busy, 1'b0);
                    check("tx_en_one_cycle", prev_tx_en, 1'b0);
                end
                if (wb_stb && !wb_stall) begin
                    acc_n = cyc_n;
                    if (exp_wb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wb_unexpected: got addr %08h expected no request", wb_addr);
                    end else begin
                        mon_r = exp_wb.pop_front();
                        check("wb_we", wb_we, mon_r.we);
                        check("wb_addr", wb_addr, mon_r.addr);
                        check("wb_sel", wb_sel, 4'hF);
                        if (mon_r.we) check("wb_wdata", wb_wdata, mon_r.data);
                    end
                end
                if (prev_acc) check("stb_single_accept", wb_stb, 1'b0);
                if (prev_ack) check("cyc_low_after_ack", wb_cyc, 1'b0);
                if (prev_cyc && !wb_cyc) drop_n = cyc_n;

                if (stb2) begin
                    if (exp_wb2.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wb14_unexpected: got addr %04h expected no request", addr2);
                    end else begin
                        mon_a = exp_wb2.pop_front();
                        check("wb14_addr", addr2, mon_a);
                        check("wb14_we_sel_data", {we2, sel2, wdata2}, {1'b0, 4'hF, 32'h0});
                    end
                end
                if (tx_en2) begin
                    if (exp_tx2.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx14_unexpected: got %02h expected no byte", tx_data2);
                    end else begin
                        mon_b = exp_tx2.pop_front();
                        check("tx14_byte", tx_data2, mon_b);
                    end
                end
            end
            prev_tx_en = tx_en;
            prev_acc   = !rst && wb_stb && !wb_stall;
            prev_ack   = !rst && wb_cyc && wb_ack && !(wb_stb && wb_stall);
            prev_cyc   = wb_cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        rst = 1'b1;
        enable = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        rx_valid2 = 1'b0;
        rx_data2 = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_tx_en", tx_en, 1'b0);
        check("rst_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b000);
        check("rst_addr", wb_addr, 32'h0);
        check("rst_wdata", wb_wdata, 32'h0);
        check("rst_sel", wb_sel, 4'hF);
        check("rst_flags", {busy, overrun, timeout_f}, 3'b000);

        // Write with 2 stall cycles, ack 3 cycles after acceptance
        cfg_stall = 2; cfg_ack_delay = 3; cfg_noack = 1'b0; slv_epoch++;
        push_wb(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        exp_tx.push_back(8'h4B);
        send_seq(72'h57_0000_0010_DEAD_BEEF, 9);
        check("write_stb_latency", wb_stb, 1'b1);
        wait_idle("write");

        // Read, acked in the accepting cycle
        cfg_stall = 0; cfg_ack_delay = 0; cfg_rdata = 32'h1234_5678; slv_epoch++;
        push_wb(1'b0, 32'h0000_0010, 32'h0);
        push_tx32(32'h1234_5678);
        send_seq(72'h52_0000_0010, 5);
        check("read_stb_latency", wb_stb, 1'b1);
        wait_idle("read");

        // Unknown command byte
        exp_tx.push_back(8'h3F);
        send_to(0, 8'h41);
        check("unknown_no_cyc", wb_cyc, 1'b0);
        wait_idle("unknown");

        // Timeout, then a read that succeeds
        cfg_noack = 1'b1; slv_epoch++;
        push_wb(1'b0, 32'h0000_0020, 32'h0);
        exp_tx.push_back(8'h54);
        send_seq(72'h52_0000_0020, 5);
        wait_idle("timeout");
        check("timeout_flag", timeout_f, 1'b1);
        // acceptance edge to cyc-drop edge distance
        check("timeout_edges", drop_n - acc_n - 1, 16);
        cfg_noack = 1'b0; cfg_ack_delay = 2; cfg_rdata = 32'hA5A5_5A5A; slv_epoch++;
        push_wb(1'b0, 32'h0000_0024, 32'h0);
        push_tx32(32'hA5A5_5A5A);
        send_seq(72'h52_0000_0024, 5);
        wait_idle("after_timeout");
        check("timeout_sticky", timeout_f, 1'b1);

        // Overrun: byte during WB_WAIT is dropped
        cfg_ack_delay = 6; cfg_rdata = 32'h0BAD_F00D; slv_epoch++;
        push_wb(1'b0, 32'h0000_0030, 32'h0);
        push_tx32(32'h0BAD_F00D);
        check("overrun_before", overrun, 1'b0);
        send_seq(72'h52_0000_0030, 5);
        tick();
        send_to(0, 8'h57);
        wait_idle("overrun");
        check("overrun_flag", overrun, 1'b1);

        // Bytes with enable low are ignored; parse position is kept
        enable = 1'b0;
        send_to(0, 8'h41);
        repeat (3) tick();
        check("enable_low_ignored", busy, 1'b0);
        cfg_ack_delay = 1; cfg_rdata = 32'h1122_3344; slv_epoch++;
        push_wb(1'b0, 32'h0000_0040, 32'h0);
        push_tx32(32'h1122_3344);
        enable = 1'b1;
        send_to(0, 8'h52);
        send_to(0, 8'h00);
        enable = 1'b0;
        send_to(0, 8'hFF);
        enable = 1'b1;
        send_seq(72'h00_0040, 3);
        wait_idle("enable_resume");

        // Reset during WB_WAIT
        cfg_ack_delay = 8; cfg_rdata = 32'hFFFF_FFFF; slv_epoch++;
        push_wb(1'b0, 32'h0000_0050, 32'h0);
        send_seq(72'h52_0000_0050, 5);
        n = 0;
        while (!(wb_cyc && !wb_stb) && n < 50) begin
            tick();
            n++;
        end
        check("reset_test_in_wait", {wb_cyc, wb_stb}, 2'b10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_flags", {overrun, timeout_f}, 2'b00);
        repeat (12) tick();
        check("late_ack_ignored", {busy, wb_cyc}, 2'b00);

        // ADDR_BITS=14 instance: 0xFF 0xFF truncates to 0x3FFF, then times out
        exp_wb2.push_back(14'h3FFF);
        exp_tx2.push_back(8'h54);
        send_to(1, 8'h52);
        send_to(1, 8'hFF);
        send_to(1, 8'hFF);
        n = 0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        check("d14_idle", busy2, 1'b0);
        check("d14_flags", {timeout2, overrun2, cyc2}, 3'b100);

        repeat (4) tick();
        check("tx_queue_empty", exp_tx.size(), 0);
        check("wb_queue_empty", exp_wb.size(), 0);
        check("tx14_queue_empty", exp_tx2.size(), 0);
        check("wb14_queue_empty", exp_wb2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
